// File: rtl/rs_alu_pool.sv
// rs_alu_pool: ALU reservation station, CDB operand snoop, single issue port.
// Define RS_OLDEST_FIRST_EN to issue the oldest ready entry instead of lowest index.
`timescale 1ns/1ps
module rs_alu_pool #(
   parameter int DEPTH   = 4,
   parameter int CDB_CNT = 3,
   parameter int XLEN    = 32,
   parameter int TAG_W   = 4,
   parameter int OP_W    = 6
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     alloc_valid,
   output logic                     alloc_ready,
   input  logic [OP_W-1:0]          alloc_op,
   input  logic [XLEN-1:0]          alloc_pc,
   input  logic [TAG_W-1:0]         alloc_tagx,
   input  logic [TAG_W-1:0]         alloc_tagy,
   input  logic [XLEN-1:0]          alloc_datax,
   input  logic [XLEN-1:0]          alloc_datay,
   input  logic [TAG_W-1:0]         alloc_tagw,
   input  logic [4:0]               alloc_rd,
   input  logic [CDB_CNT-1:0]       cdb_valid,
   input  logic [CDB_CNT*TAG_W-1:0] cdb_tag,
   input  logic [CDB_CNT*XLEN-1:0]  cdb_data,
   output logic                     issue_valid,
   input  logic                     issue_ready,
   output logic [OP_W-1:0]          issue_op,
   output logic [XLEN-1:0]          issue_pc,
   output logic [XLEN-1:0]          issue_datax,
   output logic [XLEN-1:0]          issue_datay,
   output logic [TAG_W-1:0]         issue_tagw,
   output logic [4:0]               issue_rd,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0] r_valid;
   logic [OP_W-1:0]  r_op    [DEPTH];
   logic [XLEN-1:0]  r_pc    [DEPTH];
   logic [TAG_W-1:0] r_tagx  [DEPTH];
   logic [TAG_W-1:0] r_tagy  [DEPTH];
   logic [XLEN-1:0]  r_datax [DEPTH];
   logic [XLEN-1:0]  r_datay [DEPTH];
   logic [TAG_W-1:0] r_tagw  [DEPTH];
   logic [4:0]       r_rd    [DEPTH];
   logic [CW-1:0]    r_count;
   logic             r_hold;
   logic [IW-1:0]    r_hold_idx;
`ifdef RS_OLDEST_FIRST_EN
   logic [IW-1:0]    r_rank  [DEPTH];
   logic [IW-1:0]    w_best;
   logic             w_found;
`endif

   logic [DEPTH-1:0] w_rdy;
   logic [IW-1:0]    w_free_idx;
   logic [IW-1:0]    w_pick;
   logic [IW-1:0]    w_sel;
   logic             w_alloc;
   logic             w_issue;
   logic [TAG_W-1:0] w_nx_tagx  [DEPTH];
   logic [TAG_W-1:0] w_nx_tagy  [DEPTH];
   logic [XLEN-1:0]  w_nx_datax [DEPTH];
   logic [XLEN-1:0]  w_nx_datay [DEPTH];
   logic [TAG_W-1:0] w_al_tagx;
   logic [TAG_W-1:0] w_al_tagy;
   logic [XLEN-1:0]  w_al_datax;
   logic [XLEN-1:0]  w_al_datay;

   // Scan high to low so the lowest matching bus is the last to overwrite.
   function automatic logic [TAG_W+XLEN-1:0] f_snoop(
      input logic [TAG_W-1:0]         tag,
      input logic [XLEN-1:0]          data,
      input logic [CDB_CNT-1:0]       v,
      input logic [CDB_CNT*TAG_W-1:0] t,
      input logic [CDB_CNT*XLEN-1:0]  d
   );
      logic [TAG_W+XLEN-1:0] res;
      res = {tag, data};
      if (tag != '0) begin
         for (int b = CDB_CNT - 1; b >= 0; b--) begin
            if (v[b] && t[b*TAG_W +: TAG_W] == tag)
               res = {{TAG_W{1'b0}}, d[b*XLEN +: XLEN]};
         end
      end
      return res;
   endfunction

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         {w_nx_tagx[i], w_nx_datax[i]} =
            f_snoop(r_tagx[i], r_datax[i], cdb_valid, cdb_tag, cdb_data);
         {w_nx_tagy[i], w_nx_datay[i]} =
            f_snoop(r_tagy[i], r_datay[i], cdb_valid, cdb_tag, cdb_data);
      end
      {w_al_tagx, w_al_datax} =
         f_snoop(alloc_tagx, alloc_datax, cdb_valid, cdb_tag, cdb_data);
      {w_al_tagy, w_al_datay} =
         f_snoop(alloc_tagy, alloc_datay, cdb_valid, cdb_tag, cdb_data);
   end

   always_comb begin
      w_free_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!r_valid[i]) w_free_idx = IW'(i);
      end
   end

   always_comb begin
      for (int i = 0; i < DEPTH; i++)
         w_rdy[i] = r_valid[i] && r_tagx[i] == '0 && r_tagy[i] == '0;
   end

`ifdef RS_OLDEST_FIRST_EN
   always_comb begin
      w_pick  = '0;
      w_best  = '1;
      w_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_rdy[i] && (!w_found || r_rank[i] < w_best)) begin
            w_pick  = IW'(i);
            w_best  = r_rank[i];
            w_found = 1'b1;
         end
      end
   end
`else
   always_comb begin
      w_pick = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_rdy[i]) w_pick = IW'(i);
      end
   end
`endif

   // A stalled offer stays pinned so a newly ready entry cannot displace it.
   assign w_sel       = r_hold ? r_hold_idx : w_pick;
   assign issue_valid = |w_rdy;
   assign alloc_ready = r_count < CW'(DEPTH);
   assign w_alloc     = alloc_valid && alloc_ready;
   assign w_issue     = issue_valid && issue_ready;
   assign count       = r_count;

   assign issue_op    = issue_valid ? r_op[w_sel]    : '0;
   assign issue_pc    = issue_valid ? r_pc[w_sel]    : '0;
   assign issue_datax = issue_valid ? r_datax[w_sel] : '0;
   assign issue_datay = issue_valid ? r_datay[w_sel] : '0;
   assign issue_tagw  = issue_valid ? r_tagw[w_sel]  : '0;
   assign issue_rd    = issue_valid ? r_rd[w_sel]    : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= '0;
         r_count    <= '0;
         r_hold     <= 1'b0;
         r_hold_idx <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_op[i]    <= '0;
            r_pc[i]    <= '0;
            r_tagx[i]  <= '0;
            r_tagy[i]  <= '0;
            r_datax[i] <= '0;
            r_datay[i] <= '0;
            r_tagw[i]  <= '0;
            r_rd[i]    <= '0;
`ifdef RS_OLDEST_FIRST_EN
            r_rank[i]  <= '0;
`endif
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
               r_tagx[i]  <= w_nx_tagx[i];
               r_tagy[i]  <= w_nx_tagy[i];
               r_datax[i] <= w_nx_datax[i];
               r_datay[i] <= w_nx_datay[i];
            end
         end
         if (w_issue) r_valid[w_sel] <= 1'b0;
         if (w_alloc) begin
            r_valid[w_free_idx] <= 1'b1;
            r_op[w_free_idx]    <= alloc_op;
            r_pc[w_free_idx]    <= alloc_pc;
            r_tagx[w_free_idx]  <= w_al_tagx;
            r_tagy[w_free_idx]  <= w_al_tagy;
            r_datax[w_free_idx] <= w_al_datax;
            r_datay[w_free_idx] <= w_al_datay;
            r_tagw[w_free_idx]  <= alloc_tagw;
            r_rd[w_free_idx]    <= alloc_rd;
         end
         r_count    <= r_count + CW'(w_alloc) - CW'(w_issue);
         r_hold     <= issue_valid && !issue_ready;
         r_hold_idx <= w_sel;
`ifdef RS_OLDEST_FIRST_EN
         for (int i = 0; i < DEPTH; i++) begin
            if (w_issue && r_valid[i] && r_rank[i] > r_rank[w_sel])
               r_rank[i] <= r_rank[i] - IW'(1);
         end
         if (w_alloc)
            r_rank[w_free_idx] <= IW'(r_count - CW'(w_issue));
`endif
         if (flush) begin
            r_valid <= '0;
            r_count <= '0;
            r_hold  <= 1'b0;
`ifdef RS_OLDEST_FIRST_EN
            for (int i = 0; i < DEPTH; i++) r_rank[i] <= '0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_rs_alu_pool.sv
// tb_rs_alu_pool: directed stimulus with a queue scoreboard on the issue port.
`timescale 1ns/1ps
module tb_rs_alu_pool;
   localparam int DEPTH = 4, CDB_CNT = 3, XLEN = 32, TAG_W = 4, OP_W = 6;

   logic clk = 1'b0;
   logic rst, flush, alloc_valid, alloc_ready;
   logic [OP_W-1:0] alloc_op;
   logic [XLEN-1:0] alloc_pc, alloc_datax, alloc_datay;
   logic [TAG_W-1:0] alloc_tagx, alloc_tagy, alloc_tagw;
   logic [4:0] alloc_rd;
   logic [CDB_CNT-1:0] cdb_valid;
   logic [CDB_CNT*TAG_W-1:0] cdb_tag;
   logic [CDB_CNT*XLEN-1:0] cdb_data;
   logic issue_valid, issue_ready;
   logic [OP_W-1:0] issue_op;
   logic [XLEN-1:0] issue_pc, issue_datax, issue_datay;
   logic [TAG_W-1:0] issue_tagw;
   logic [4:0] issue_rd;
   logic [$clog2(DEPTH):0] count;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  dx;
      logic [XLEN-1:0]  dy;
      logic [TAG_W-1:0] tw;
      logic [4:0]       rd;
   } pay_t;

   pay_t q[$];
   int checks = 0;
   int errors = 0;

   rs_alu_pool #(.DEPTH(DEPTH), .CDB_CNT(CDB_CNT), .XLEN(XLEN),
                 .TAG_W(TAG_W), .OP_W(OP_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
      .alloc_op(alloc_op), .alloc_pc(alloc_pc),
      .alloc_tagx(alloc_tagx), .alloc_tagy(alloc_tagy),
      .alloc_datax(alloc_datax), .alloc_datay(alloc_datay),
      .alloc_tagw(alloc_tagw), .alloc_rd(alloc_rd),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_op(issue_op), .issue_pc(issue_pc),
      .issue_datax(issue_datax), .issue_datay(issue_datay),
      .issue_tagw(issue_tagw), .issue_rd(issue_rd), .count(count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic neg();
      @(negedge clk);
   endtask

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic set_alloc(input logic [5:0] op, input logic [31:0] pc,
                            input logic [3:0] tx, input logic [31:0] dx,
                            input logic [3:0] ty, input logic [31:0] dy,
                            input logic [3:0] tw, input logic [4:0] rd);
      alloc_valid = 1'b1;
      alloc_op = op;     alloc_pc = pc;
      alloc_tagx = tx;   alloc_datax = dx;
      alloc_tagy = ty;   alloc_datay = dy;
      alloc_tagw = tw;   alloc_rd = rd;
   endtask

   task automatic exp_push(input logic [5:0] op, input logic [31:0] pc,
                           input logic [31:0] dx, input logic [31:0] dy,
                           input logic [3:0] tw, input logic [4:0] rd);
      pay_t p;
      p = '{op: op, pc: pc, dx: dx, dy: dy, tw: tw, rd: rd};
      q.push_back(p);
   endtask

   // Monitor: every offered payload must equal the scoreboard head.
   always @(negedge clk) begin
      if (!rst && issue_valid) begin
         pay_t got;
         got = '{op: issue_op, pc: issue_pc, dx: issue_datax,
                 dy: issue_datay, tw: issue_tagw, rd: issue_rd};
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_issue got pc %0h rd %0d",
                     issue_pc, issue_rd);
         end else begin
            if (got !== q[0]) begin
               errors++;
               $display("FAIL issue_payload got %h expected %h", got, q[0]);
            end
            if (issue_ready) void'(q.pop_front());
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0;
      alloc_op = '0; alloc_pc = '0; alloc_tagx = '0; alloc_tagy = '0;
      alloc_datax = '0; alloc_datay = '0; alloc_tagw = '0; alloc_rd = '0;
      cdb_valid = '0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      // reset state
      neg();
      chk("rst_alloc_ready", 32'(alloc_ready), 1);
      chk("rst_issue_valid", 32'(issue_valid), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_issue_datax", issue_datax, 0);
      chk("rst_issue_pc", issue_pc, 0);
      chk("rst_issue_op", 32'(issue_op), 0);
      tick();

      // both operands ready at allocation
      issue_ready = 1'b1;
      set_alloc(6'd1, 32'h100, 4'd0, 32'd5, 4'd0, 32'd7, 4'd3, 5'd10);
      exp_push(6'd1, 32'h100, 32'd5, 32'd7, 4'd3, 5'd10);
      tick();
      alloc_valid = 1'b0;
      neg();
      chk("t1_issue_valid", 32'(issue_valid), 1);
      chk("t1_count_1", 32'(count), 1);
      tick();
      neg();
      chk("t1_count_0", 32'(count), 0);
      chk("t1_idle", 32'(issue_valid), 0);
      tick();

      // tagx wakes from bus 1; bus 2 carries the same tag but loses
      set_alloc(6'd2, 32'h104, 4'd2, 32'h11, 4'd0, 32'h22, 4'd5, 5'd11);
      exp_push(6'd2, 32'h104, 32'h55, 32'h22, 4'd5, 5'd11);
      tick();
      alloc_valid = 1'b0;
      neg();
      chk("t2_wait", 32'(issue_valid), 0);
      tick();
      cdb_valid = 3'b110;
      cdb_tag = {4'd2, 4'd2, 4'd0};
      cdb_data = {32'h99, 32'h55, 32'h0};
      neg();
      chk("t2_no_comb_path", 32'(issue_valid), 0);
      tick();
      cdb_valid = '0;
      neg();
      chk("t2_issue_valid", 32'(issue_valid), 1);
      tick();
      neg();
      chk("t2_count_0", 32'(count), 0);
      tick();

      // same-cycle bypass on tagy; a tag-0 broadcast must not disturb datax
      set_alloc(6'd3, 32'h108, 4'd0, 32'd9, 4'd4, 32'h33, 4'd6, 5'd12);
      cdb_valid = 3'b011;
      cdb_tag = {4'd0, 4'd0, 4'd4};
      cdb_data = {32'h0, 32'hEE, 32'hAA};
      exp_push(6'd3, 32'h108, 32'd9, 32'hAA, 4'd6, 5'd12);
      tick();
      alloc_valid = 1'b0;
      cdb_valid = '0;
      neg();
      chk("t3_bypass_valid", 32'(issue_valid), 1);
      tick();
      neg();
      chk("t3_count_0", 32'(count), 0);
      tick();

      // fill, overflow attempt, flush
      issue_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         set_alloc(6'd4, 32'h200 + 32'(4 * i), 4'd7, 32'(i), 4'd0, 32'd0,
                   4'd1, 5'(i));
         tick();
      end
      alloc_valid = 1'b0;
      neg();
      chk("t4_full_ready", 32'(alloc_ready), 0);
      chk("t4_full_count", 32'(count), 4);
      tick();
      set_alloc(6'd5, 32'h300, 4'd0, 32'd1, 4'd0, 32'd2, 4'd2, 5'd30);
      tick();
      alloc_valid = 1'b0;
      neg();
      chk("t4_ignored_count", 32'(count), 4);
      chk("t4_ignored_issue", 32'(issue_valid), 0);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      neg();
      chk("t4_flush_count", 32'(count), 0);
      chk("t4_flush_ready", 32'(alloc_ready), 1);
      chk("t4_flush_issue", 32'(issue_valid), 0);
      tick();
      cdb_valid = 3'b001;
      cdb_tag = {4'd0, 4'd0, 4'd7};
      cdb_data = {32'h0, 32'h0, 32'h77};
      tick();
      cdb_valid = '0;
      neg();
      chk("t4_no_revive", 32'(issue_valid), 0);
      tick();

      // allocate and issue in the same cycle
      issue_ready = 1'b1;
      set_alloc(6'd6, 32'h400, 4'd0, 32'd1, 4'd0, 32'd2, 4'd2, 5'd20);
      exp_push(6'd6, 32'h400, 32'd1, 32'd2, 4'd2, 5'd20);
      tick();
      set_alloc(6'd7, 32'h404, 4'd0, 32'd3, 4'd0, 32'd4, 4'd3, 5'd21);
      exp_push(6'd7, 32'h404, 32'd3, 32'd4, 4'd3, 5'd21);
      neg();
      chk("t5_count_before", 32'(count), 1);
      tick();
      alloc_valid = 1'b0;
      neg();
      chk("t5_count_same", 32'(count), 1);
      tick();
      neg();
      chk("t5_count_0", 32'(count), 0);
      tick();

      // selection order: idx2 allocated before idx0 is reused
      issue_ready = 1'b0;
      set_alloc(6'd8, 32'h500, 4'd8, 32'd0, 4'd0, 32'd1, 4'd1, 5'd1);
      tick();
      set_alloc(6'd9, 32'h504, 4'd9, 32'd0, 4'd0, 32'd2, 4'd1, 5'd2);
      tick();
      set_alloc(6'd10, 32'h508, 4'd10, 32'd0, 4'd0, 32'd3, 4'd1, 5'd3);
      tick();
      alloc_valid = 1'b0;
      exp_push(6'd8, 32'h500, 32'h80, 32'd1, 4'd1, 5'd1);
      cdb_valid = 3'b001;
      cdb_tag = {4'd0, 4'd0, 4'd8};
      cdb_data = {32'h0, 32'h0, 32'h80};
      issue_ready = 1'b1;
      tick();
      cdb_valid = '0;
      neg();
      chk("t6_e0_valid", 32'(issue_valid), 1);
      tick();
      issue_ready = 1'b0;
      set_alloc(6'd11, 32'h50C, 4'd11, 32'd0, 4'd0, 32'd4, 4'd1, 5'd4);
      tick();
      alloc_valid = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
      exp_push(6'd10, 32'h508, 32'hA0, 32'd3, 4'd1, 5'd3);
      exp_push(6'd11, 32'h50C, 32'hB0, 32'd4, 4'd1, 5'd4);
`else
      exp_push(6'd11, 32'h50C, 32'hB0, 32'd4, 4'd1, 5'd4);
      exp_push(6'd10, 32'h508, 32'hA0, 32'd3, 4'd1, 5'd3);
`endif
      cdb_valid = 3'b011;
      cdb_tag = {4'd0, 4'd11, 4'd10};
      cdb_data = {32'h0, 32'hB0, 32'hA0};
      tick();
      cdb_valid = '0;
      for (int k = 0; k < 3; k++) begin
         neg();
         chk("t6_stall_valid", 32'(issue_valid), 1);
         tick();
      end
      issue_ready = 1'b1;
      tick();
      tick();
      neg();
      chk("t6_count_1", 32'(count), 1);
      tick();
      exp_push(6'd9, 32'h504, 32'h90, 32'd2, 4'd1, 5'd2);
      cdb_valid = 3'b100;
      cdb_tag = {4'd9, 4'd0, 4'd0};
      cdb_data = {32'h90, 32'h0, 32'h0};
      tick();
      cdb_valid = '0;
      neg();
      chk("t6_e1_valid", 32'(issue_valid), 1);
      tick();
      neg();
      chk("t6_count_0", 32'(count), 0);
      chk("sb_drained", 32'(q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rs_alu_pool.md
Name: rs_alu_pool

Overview:
Parametrised ALU reservation station. DEPTH entries, allocated from a single dispatch port. Entries snoop CDB_CNT result broadcast buses for pending operand tags, and one ready entry per cycle is issued to the ALU over a valid/ready handshake. Sits between the instruction allocator and the ALU executor.

Parameters:
DEPTH, 4, number of entries (power of two, >=2)
CDB_CNT, 3, number of result broadcast buses snooped
XLEN, 32, operand/pc width
TAG_W, 4, register tag width; tag value 0 means operand available (unlocked)
OP_W, 6, decoded op width

Ports:
clk  in  1  clock
rst  in  1  reset (synchronous, active-high)
flush  in  1  discard all entries (mispredict)
alloc_valid  in  1  dispatch request
alloc_ready  out  1  at least one free entry
alloc_op  in  OP_W  op
alloc_pc  in  XLEN  instruction pc
alloc_tagx / alloc_tagy  in  TAG_W  source tags (0 = data valid)
alloc_datax / alloc_datay  in  XLEN  source data
alloc_tagw  in  TAG_W  destination tag
alloc_rd  in  5  destination register address
cdb_valid  in  CDB_CNT  bus i broadcasting
cdb_tag  in  CDB_CNT*TAG_W  bus i tag (slice i)
cdb_data  in  CDB_CNT*XLEN  bus i result (slice i)
issue_valid  out  1  issue payload valid
issue_ready  in  1  ALU accepts
issue_op, issue_pc, issue_datax, issue_datay, issue_tagw, issue_rd  out  as alloc  payload of selected entry
count  out  $clog2(DEPTH)+1  valid entries

Behaviour:
- Reset: rst synchronous, active-high; clock clk. All entries invalid, all tags 0, data 0. Outputs after reset: alloc_ready=1, issue_valid=0, all issue payload 0, count=0.
- Entry state: valid, op, pc, tagx, tagy, datax, datay, tagw, rd. Entry ready = valid && tagx==0 && tagy==0.
- Allocation: alloc_valid && alloc_ready writes the lowest-index free entry at the clock edge.
  - alloc_ready = (count < DEPTH) from registered state only. An entry freed by issue this cycle is not usable until the next cycle.
  - alloc_valid while !alloc_ready: ignored, no state change.
- Snoop: each cycle, for every valid entry and each operand with tag!=0, a matching cdb_valid[i]/cdb_tag[i] loads cdb_data[i] and clears the tag to 0.
  - cdb_tag==0 is never a match.
  - Multiple buses matching one operand: lowest bus index wins.
  - Allocating operands also snoop the same-cycle CDB (bypass), so a tag broadcast in the allocation cycle is captured.
- Issue selection: combinational over registered state. issue_valid = any ready entry; payload comes from the selected entry (lowest-index ready entry unless the optional feature is on).
  - issue_valid && issue_ready frees the selected entry at the edge.
  - Payload must hold stable while issue_valid && !issue_ready, unless flush.
- Latency: allocation with both tags 0 -> issue_valid next cycle. CDB capture in cycle N -> entry eligible in cycle N+1. No CDB-to-issue combinational path.
- Simultaneous allocate and issue in one cycle: both occur; count unchanged.
- count: +1 on allocate, -1 on issue, saturates neither way (cannot exceed DEPTH by construction).
- flush: next cycle all entries invalid, count=0. Priority flush > allocate/issue; an issue handshake in the flush cycle still counts as consumed by the ALU.
- rst overrides flush.

Optional Feature:
RS_OLDEST_FIRST_EN
- Defined: each entry carries an age rank ($clog2(DEPTH) bits).
  - A new entry gets rank = number of valid entries remaining after this cycle's issue.
  - On issue of an entry with rank a, every valid entry with rank > a decrements.
  - Selection = ready entry with minimum rank (oldest first).
  - Ranks are cleared by rst/flush.
- Undefined: no age state; selection is the lowest-index ready entry.

Test Plan:
- Reset then idle -> alloc_ready=1, issue_valid=0, count=0, payloads 0.
- Allocate op=ADD, tagx=0, datax=5, tagy=0, datay=7, tagw=3, rd=10, with issue_ready=1 -> next cycle issue_valid=1 with datax=5, datay=7, rd=10; following cycle count=0.
- Allocate tagx=2, tagy=0; two cycles later cdb_valid[1]=1, tag 2, data 0x55 -> issue_valid=1 the next cycle with datax=0x55.
- Allocate with tagy=4 while cdb_valid[0]=1, tag 4, data 0xAA in the same cycle (bypass) -> issue_valid next cycle with datay=0xAA.
- Fill DEPTH=4 entries with tags pending, issue_ready=0 -> alloc_ready=0, count=4; a fifth alloc_valid is ignored; assert flush -> count=0, alloc_ready=1.
- Allocate entries to index 2 then index 0 (index 0 freed earlier), both made ready in the same cycle -> with RS_OLDEST_FIRST_EN the index 2 entry issues first; without it the index 0 entry issues first. Hold issue_ready=0 -> payload stable.
